// File: rtl/dea_frame_loader.sv
`timescale 1ns/1ps
// dea_frame_loader: parses a length-prefixed frame (N, N data bytes, K, K key
// bytes) from a four-phase receiver handshake, buffers it, then hands out one
// (data, key, index) pair per downstream handshake with the key index cycling
// through 0..K-1.
module dea_frame_loader #(
    parameter int MAX_DATA = 100,
    parameter int MAX_KEY  = 3
) (
    input  logic       Clk_100M,
    input  logic       Reset,
    input  logic [7:0] Rx_Data,
    input  logic       Rx_Ready,
    output logic       Rx_Ack,
    output logic [7:0] Pair_Data,
    output logic [7:0] Pair_Key,
    output logic [7:0] Pair_Index,
    output logic       Pair_Valid,
    input  logic       Pair_Ack,
    output logic [7:0] Data_Len,
    output logic [7:0] Key_Len,
    output logic       Busy,
    output logic       Frame_Done,
    output logic       Frame_Error
);

    localparam int         DAW        = (MAX_DATA > 1) ? $clog2(MAX_DATA) : 1;
    localparam int         KAW        = (MAX_KEY > 1) ? $clog2(MAX_KEY) : 1;
    localparam logic [7:0] MAX_DATA_B = 8'(MAX_DATA);
    localparam logic [7:0] MAX_KEY_B  = 8'(MAX_KEY);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
        S_KLEN,
        S_KEY,
        S_ISSUE,
        S_WAIT
    } state_t;

    state_t     state_q, state_d;
    logic       rx_ack_q, rx_ack_d;
    logic [7:0] data_len_q, data_len_d;
    logic [7:0] key_len_q, key_len_d;
    logic [7:0] dcnt_q, dcnt_d;
    logic [7:0] kcnt_q, kcnt_d;
    logic [7:0] idx_q, idx_d;
    logic [7:0] kidx_q, kidx_d;
    logic [7:0] pair_data_q, pair_data_d;
    logic [7:0] pair_key_q, pair_key_d;
    logic [7:0] pair_index_q, pair_index_d;
    logic       pair_valid_q, pair_valid_d;
    logic       frame_done_q, frame_done_d;
    logic       frame_error_q, frame_error_d;

    logic       data_we, key_we;
    logic       capture;
    logic [7:0] data_mem [MAX_DATA];
    logic [7:0] key_mem  [MAX_KEY];

    // A byte is taken once per Rx_Ready assertion, and only while parsing.
    assign capture = Rx_Ready && !rx_ack_q &&
                     (state_q inside {S_LEN, S_DATA, S_KLEN, S_KEY});

    // Next-state, counters, handshake and registered pair outputs.
    always_comb begin
        state_d       = state_q;
        rx_ack_d      = rx_ack_q;
        data_len_d    = data_len_q;
        key_len_d     = key_len_q;
        dcnt_d        = dcnt_q;
        kcnt_d        = kcnt_q;
        idx_d         = idx_q;
        kidx_d        = kidx_q;
        pair_data_d   = pair_data_q;
        pair_key_d    = pair_key_q;
        pair_index_d  = pair_index_q;
        pair_valid_d  = pair_valid_q;
        frame_done_d  = 1'b0;
        frame_error_d = 1'b0;
        data_we       = 1'b0;
        key_we        = 1'b0;

        // Ack rises on capture and drops once Ready is seen low, in any state.
        if (capture) begin
            rx_ack_d = 1'b1;
        end else if (!Rx_Ready) begin
            rx_ack_d = 1'b0;
        end

        case (state_q)
            S_LEN: begin
                if (capture) begin
                    if (Rx_Data == 8'd0 || Rx_Data > MAX_DATA_B) begin
                        frame_error_d = 1'b1;
                    end else begin
                        data_len_d = Rx_Data;
                        dcnt_d     = 8'd0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (capture) begin
                    data_we = 1'b1;
                    dcnt_d  = dcnt_q + 8'd1;
                    if (dcnt_q == data_len_q - 8'd1) begin
                        state_d = S_KLEN;
                    end
                end
            end
            S_KLEN: begin
                if (capture) begin
                    if (Rx_Data == 8'd0 || Rx_Data > MAX_KEY_B) begin
                        frame_error_d = 1'b1;
                        state_d       = S_LEN;
                    end else begin
                        key_len_d = Rx_Data;
                        kcnt_d    = 8'd0;
                        state_d   = S_KEY;
                    end
                end
            end
            S_KEY: begin
                if (capture) begin
                    key_we = 1'b1;
                    kcnt_d = kcnt_q + 8'd1;
                    if (kcnt_q == key_len_q - 8'd1) begin
                        idx_d   = 8'd0;
                        kidx_d  = 8'd0;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // First cycle loads the fields; Valid follows with them stable.
                // An ack already high on entry is ignored until Valid is up.
                if (!pair_valid_q) begin
                    pair_data_d  = data_mem[idx_q[DAW-1:0]];
                    pair_key_d   = key_mem[kidx_q[KAW-1:0]];
                    pair_index_d = idx_q;
                    pair_valid_d = 1'b1;
                end else if (Pair_Ack) begin
                    pair_valid_d = 1'b0;
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!Pair_Ack) begin
                    if (idx_q == data_len_q - 8'd1) begin
                        frame_done_d = 1'b1;
                        state_d      = S_LEN;
                    end else begin
                        idx_d   = idx_q + 8'd1;
                        kidx_d  = (kidx_q == key_len_q - 8'd1) ? 8'd0 : kidx_q + 8'd1;
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_LEN;
        endcase
    end

    // Control and output registers; reset aborts any frame in progress.
    always_ff @(posedge Clk_100M or posedge Reset) begin
        if (Reset) begin
            state_q       <= S_LEN;
            rx_ack_q      <= 1'b0;
            data_len_q    <= 8'd0;
            key_len_q     <= 8'd0;
            dcnt_q        <= 8'd0;
            kcnt_q        <= 8'd0;
            idx_q         <= 8'd0;
            kidx_q        <= 8'd0;
            pair_data_q   <= 8'd0;
            pair_key_q    <= 8'd0;
            pair_index_q  <= 8'd0;
            pair_valid_q  <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_ack_q      <= rx_ack_d;
            data_len_q    <= data_len_d;
            key_len_q     <= key_len_d;
            dcnt_q        <= dcnt_d;
            kcnt_q        <= kcnt_d;
            idx_q         <= idx_d;
            kidx_q        <= kidx_d;
            pair_data_q   <= pair_data_d;
            pair_key_q    <= pair_key_d;
            pair_index_q  <= pair_index_d;
            pair_valid_q  <= pair_valid_d;
            frame_done_q  <= frame_done_d;
            frame_error_q <= frame_error_d;
        end
    end

    // Frame buffers; contents are only meaningful after being written.
    always_ff @(posedge Clk_100M) begin
        if (data_we) data_mem[dcnt_q[DAW-1:0]] <= Rx_Data;
        if (key_we)  key_mem[kcnt_q[KAW-1:0]]  <= Rx_Data;
    end

    assign Rx_Ack      = rx_ack_q;
    assign Pair_Data   = pair_data_q;
    assign Pair_Key    = pair_key_q;
    assign Pair_Index  = pair_index_q;
    assign Pair_Valid  = pair_valid_q;
    assign Data_Len    = data_len_q;
    assign Key_Len     = key_len_q;
    assign Busy        = (state_q != S_LEN);
    assign Frame_Done  = frame_done_q;
    assign Frame_Error = frame_error_q;

endmodule
